// File: rtl/sdram_probe_clear.sv
// sdram_probe_clear: sequencer in front of the SDRAM controller request port.
// After the controller reports ready it detects the installed module size by an
// aliasing test. It then zero-fills the detected range. It publishes size flags
// and a clear-progress status.
//
// Build option: define SDRAM_PROBE_VERIFY_EN to add a read-back sweep after the
// clear that flags any nonzero word on err. Without it err is tied low.
//
// Ports:
//   clk_sys    system clock
//   RESET      synchronous active-high reset
//   sd_ready   controller idle/ready
//   sd_dout    controller read data, valid while sd_ready is high after a read
//   sd_addr    request word address (registered with the strobe)
//   sd_din     request write data (registered with the strobe)
//   sd_we      write strobe, single-cycle pulse
//   sd_rd      read strobe, single-cycle pulse
//   size_cfg   [2] full 2^ADDR_W, [1] half, [0] quarter size present
//   cfg_valid  size_cfg is final
//   clr_busy   zero-fill (and read-back, if built in) in progress
//   clr_done   zero-fill complete, sticky until RESET
//   err        read-back found a nonzero word (verify builds only)
module sdram_probe_clear #(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned CLR_PAUSE = 0
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              sd_ready,
    input  logic [15:0]       sd_dout,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_din,
    output logic              sd_we,
    output logic              sd_rd,
    output logic [2:0]        size_cfg,
    output logic              cfg_valid,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PA = ADDR_W'(1) << (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] PB = ADDR_W'(1) << (ADDR_W - 2);
    localparam logic [ADDR_W-1:0] PC = '0;
    localparam logic [ADDR_W-1:0] PD = ADDR_W'(1) << (ADDR_W - 3);

    localparam logic [15:0] DAT_A = 16'd3128;
    localparam logic [15:0] DAT_B = 16'd2064;
    localparam logic [15:0] DAT_C = 16'd1032;
    localparam logic [15:0] DAT_D = 16'd12345;

    // Counter is one bit wider than the address so the top word never wraps.
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] CT_FULL = (ONE << ADDR_W) - ONE;
    localparam logic [ADDR_W:0] CT_HALF = (ONE << (ADDR_W - 1)) - ONE;
    localparam logic [ADDR_W:0] CT_QTR  = (ONE << (ADDR_W - 2)) - ONE;

    typedef enum logic [3:0] {
        StWaitInit,
        StWA,
        StWB,
        StWC,
        StWD,
        StRA,
        StRB,
        StRC,
        StClear,
`ifdef SDRAM_PROBE_VERIFY_EN
        StVerify,
`endif
        StDone
    } state_e;

    // Each access walks Issue -> Gap -> (Sample for reads | Pause for clears).
    typedef enum logic [1:0] {PhIssue, PhGap, PhSample, PhPause} phase_e;

    state_e            state;
    state_e            next_st;
    phase_e            phase;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   ct;
    logic [31:0]       pause_cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_din;
    logic              req_rd;

    // Request contents and successor for the current step.
    always_comb begin
        req_addr = '0;
        req_din  = '0;
        req_rd   = 1'b0;
        next_st  = StDone;
        unique case (state)
            StWA:    begin req_addr = PA; req_din = DAT_A; next_st = StWB; end
            StWB:    begin req_addr = PB; req_din = DAT_B; next_st = StWC; end
            StWC:    begin req_addr = PC; req_din = DAT_C; next_st = StWD; end
            StWD:    begin req_addr = PD; req_din = DAT_D; next_st = StRA; end
            StRA:    begin req_addr = PA; req_rd = 1'b1;   next_st = StRB; end
            StRB:    begin req_addr = PB; req_rd = 1'b1;   next_st = StRC; end
            StRC:    begin req_addr = PC; req_rd = 1'b1;   next_st = StClear; end
            StClear: req_addr = cnt[ADDR_W-1:0];
`ifdef SDRAM_PROBE_VERIFY_EN
            StVerify: begin req_addr = cnt[ADDR_W-1:0]; req_rd = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state     <= StWaitInit;
            phase     <= PhIssue;
            cnt       <= '0;
            ct        <= '0;
            pause_cnt <= '0;
            sd_addr   <= '0;
            sd_din    <= '0;
            sd_we     <= 1'b0;
            sd_rd     <= 1'b0;
            size_cfg  <= '0;
            cfg_valid <= 1'b0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
`ifdef SDRAM_PROBE_VERIFY_EN
            err       <= 1'b0;
`endif
        end else begin
            sd_we <= 1'b0;
            sd_rd <= 1'b0;
            unique case (phase)
                PhIssue: begin
                    if (state == StWaitInit) begin
                        if (sd_ready) state <= StWA;
                    end else if (state != StDone && sd_ready) begin
                        sd_addr <= req_addr;
                        sd_din  <= req_din;
                        sd_we   <= ~req_rd;
                        sd_rd   <= req_rd;
                        phase   <= PhGap;
                    end
                end
                // Controller may still show ready here; it is ignored.
                PhGap: begin
                    if (req_rd) begin
                        phase <= PhSample;
                    end else if (state == StClear) begin
                        if (cnt == ct) begin
                            cnt   <= '0;
                            phase <= PhIssue;
`ifdef SDRAM_PROBE_VERIFY_EN
                            state <= StVerify;
`else
                            state    <= StDone;
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
`endif
                        end else begin
                            cnt       <= cnt + ONE;
                            pause_cnt <= '0;
                            phase     <= (CLR_PAUSE == 0) ? PhIssue : PhPause;
                        end
                    end else begin
                        state <= next_st;
                        phase <= PhIssue;
                    end
                end
                PhSample: begin
                    if (sd_ready) begin
                        phase <= PhIssue;
                        unique case (state)
                            StRA: begin
                                size_cfg[2] <= (sd_dout == DAT_A);
                                state       <= StRB;
                            end
                            StRB: begin
                                size_cfg[1] <= (sd_dout == DAT_B);
                                state       <= StRC;
                            end
                            StRC: begin
                                size_cfg[0] <= (sd_dout == DAT_C);
                                cfg_valid   <= 1'b1;
                                if (size_cfg[2] || size_cfg[1] || sd_dout == DAT_C) begin
                                    ct       <= size_cfg[2] ? CT_FULL :
                                                size_cfg[1] ? CT_HALF : CT_QTR;
                                    cnt      <= '0;
                                    clr_busy <= 1'b1;
                                    state    <= StClear;
                                end else begin
                                    // Nothing answered: no range to clear.
                                    clr_done <= 1'b1;
                                    state    <= StDone;
                                end
                            end
`ifdef SDRAM_PROBE_VERIFY_EN
                            StVerify: begin
                                if (sd_dout != 16'h0) err <= 1'b1;
                                if (cnt == ct) begin
                                    clr_busy <= 1'b0;
                                    clr_done <= 1'b1;
                                    state    <= StDone;
                                end else begin
                                    cnt <= cnt + ONE;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                PhPause: begin
                    if (pause_cnt == CLR_PAUSE - 32'd1) phase <= PhIssue;
                    else pause_cnt <= pause_cnt + 32'd1;
                end
                default: phase <= PhIssue;
            endcase
        end
    end

`ifndef SDRAM_PROBE_VERIFY_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_probe_clear.sv
// Bench for sdram_probe_clear with ADDR_W=8 against a behavioural SDRAM
// controller: randomized access latency, random initial memory contents and
// selectable module size (256 words, 64 words aliased, or absent).
module tb_sdram_probe_clear;

    localparam int unsigned AW = 8;
`ifdef SDRAM_PROBE_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic          clk_sys  = 1'b0;
    logic          RESET    = 1'b1;
    logic          sd_ready = 1'b0;
    logic [15:0]   sd_dout  = 16'h0;
    logic [AW-1:0] sd_addr;
    logic [15:0]   sd_din;
    logic          sd_we;
    logic          sd_rd;
    logic [2:0]    size_cfg;
    logic          cfg_valid;
    logic          clr_busy;
    logic          clr_done;
    logic          err;

    always #5 clk_sys = ~clk_sys;

    sdram_probe_clear #(
        .ADDR_W    (AW),
        .CLR_PAUSE (0)
    ) dut (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .sd_ready  (sd_ready),
        .sd_dout   (sd_dout),
        .sd_addr   (sd_addr),
        .sd_din    (sd_din),
        .sd_we     (sd_we),
        .sd_rd     (sd_rd),
        .size_cfg  (size_cfg),
        .cfg_valid (cfg_valid),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .err       (err)
    );

    typedef struct packed {
        logic        rd;
        logic [7:0]  addr;
        logic [15:0] din;
    } req_t;

    // Controller model state. mode: 0 = 256 words, 1 = 64 words, 2 = absent.
    req_t        log_q[$];
    logic [15:0] mem [256];
    int          mode         = 0;
    bit          slow         = 1'b0;
    bit          bad10        = 1'b0;
    int          viol         = 0;
    int          busy_strobes = 0;
    int          busy_cycles  = 0;
    int          lat          = 0;
    bit          prev_strobe  = 1'b0;
    logic [15:0] pend         = 16'h0;

    int total = 0;
    int bad   = 0;

    req_t        exp_q[$];
    logic [2:0]  exp_size;
    int          exp_ct;
    int          base_log, base_viol, base_bstr, base_bcyc;

    function automatic logic [7:0] map_addr(input int m, input logic [7:0] a);
        return (m == 1) ? (a & 8'h3F) : a;
    endfunction

    always @(negedge clk_sys) begin
        req_t r;
        if (clr_busy) busy_cycles++;
        if (RESET) begin
            foreach (mem[i]) mem[i] = 16'($urandom);
            sd_ready    = 1'b0;
            lat         = 4 + $urandom_range(0, 4);
            prev_strobe = 1'b0;
        end else begin
            if (sd_we && sd_rd) viol++;
            if ((sd_we || sd_rd) && (prev_strobe || !sd_ready)) viol++;
            prev_strobe = sd_we || sd_rd;
            if (sd_we || sd_rd) begin
                r = {sd_rd, sd_addr, sd_din};
                log_q.push_back(r);
                if (clr_busy) busy_strobes++;
                if (sd_we) begin
                    if (mode != 2) mem[map_addr(mode, sd_addr)] = sd_din;
                end else if (mode == 2) pend = 16'hFFFF;
                else if (bad10 && sd_addr == 8'h10) pend = 16'h0001;
                else pend = mem[map_addr(mode, sd_addr)];
                sd_ready = 1'b0;
                sd_dout  = 16'($urandom);
                lat      = slow ? 100 : 3 + $urandom_range(0, 2);
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    sd_ready = 1'b1;
                    sd_dout  = pend;
                end
            end
        end
    end

    // Expected request stream and size flags from the aliasing rules.
    task automatic build_exp(input int m, input bit verify);
        logic [15:0] al [256];
        logic [7:0]  pa [4] = '{8'h80, 8'h40, 8'h00, 8'h20};
        logic [15:0] pv [4] = '{16'd3128, 16'd2064, 16'd1032, 16'd12345};
        req_t        r;
        exp_q.delete();
        foreach (al[i]) al[i] = 16'h0;
        for (int i = 0; i < 4; i++) begin
            r = {1'b0, pa[i], pv[i]};
            exp_q.push_back(r);
            if (m != 2) al[map_addr(m, pa[i])] = pv[i];
        end
        for (int i = 0; i < 3; i++) begin
            r = {1'b1, pa[i], 16'h0};
            exp_q.push_back(r);
            exp_size[2-i] = (m != 2) && (al[map_addr(m, pa[i])] == pv[i]);
        end
        // Largest present size sets the last word to clear.
        exp_ct = exp_size[2] ? 255 : exp_size[1] ? 127 : exp_size[0] ? 63 : -1;
        for (int i = 0; i <= exp_ct; i++) begin
            r = {1'b0, 8'(i), 16'h0};
            exp_q.push_back(r);
        end
        if (verify) begin
            for (int i = 0; i <= exp_ct; i++) begin
                r = {1'b1, 8'(i), 16'h0};
                exp_q.push_back(r);
            end
        end
    endtask

    function automatic bit same_req(input req_t a, input req_t b);
        return a.rd == b.rd && a.addr == b.addr && (a.rd || a.din == b.din);
    endfunction

    // Index of first disagreement between logged and expected streams, -1 if equal.
    function automatic int first_diff(input int base);
        int n = log_q.size() - base;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= n) return i;
            if (!same_req(log_q[base + i], exp_q[i])) return i;
        end
        return (n == exp_q.size()) ? -1 : exp_q.size();
    endfunction

    task automatic apply_reset();
        RESET = 1'b1;
        repeat (3) @(negedge clk_sys);
        #1;
        base_log  = log_q.size();
        base_viol = viol;
        base_bstr = busy_strobes;
        base_bcyc = busy_cycles;
        RESET = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output bit ok, output int done_len);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            #1;
            if (clr_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        done_len = log_q.size();
        repeat (20) @(negedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        total++;
        if ({sd_we, sd_rd, sd_addr, sd_din, size_cfg, cfg_valid, clr_busy, clr_done, err}
            !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b rd=%b addr=%h din=%h cfg=%b v=%b busy=%b done=%b err=%b, expected all 0",
                     sd_we, sd_rd, sd_addr, sd_din, size_cfg, cfg_valid, clr_busy, clr_done, err);
        end
    endtask

    task automatic test_size_detect(input int m, input string nm);
        bit ok;
        int done_len, d, nz;
        mode = m;
        build_exp(m, VERIFY_ON);
        apply_reset();
        run_to_done(20000, ok, done_len);
        total++;
        if (!ok) begin bad++; $display("FAIL %s done_timeout: clr_done=%b, expected 1", nm, clr_done); end
        total++;
        if (size_cfg !== exp_size) begin
            bad++; $display("FAIL %s size_cfg: got %b, expected %b", nm, size_cfg, exp_size);
        end
        total++;
        if ({cfg_valid, clr_busy, clr_done} !== 3'b101) begin
            bad++; $display("FAIL %s flags: got valid/busy/done=%b, expected 101", nm, {cfg_valid, clr_busy, clr_done});
        end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL %s err: got %b, expected 0", nm, err); end
        d = first_diff(base_log);
        total++;
        if (d >= 0) begin
            bad++;
            $display("FAIL %s request_log: got %0d requests, differs at %0d, expected %0d requests",
                     nm, log_q.size() - base_log, d, exp_q.size());
        end
        total++;
        if (log_q.size() != done_len) begin
            bad++; $display("FAIL %s strobes_after_done: got %0d, expected 0", nm, log_q.size() - done_len);
        end
        total++;
        if (viol != base_viol) begin
            bad++; $display("FAIL %s protocol: got %0d violations, expected 0", nm, viol - base_viol);
        end
        total++;
        if (busy_strobes - base_bstr != (exp_ct + 1) * (VERIFY_ON ? 2 : 1)) begin
            bad++;
            $display("FAIL %s busy_strobes: got %0d, expected %0d", nm, busy_strobes - base_bstr,
                     (exp_ct + 1) * (VERIFY_ON ? 2 : 1));
        end
        total++;
        if ((busy_cycles - base_bcyc > 0) != (exp_ct >= 0)) begin
            bad++; $display("FAIL %s busy_seen: got %0d busy cycles, expected busy=%b", nm, busy_cycles - base_bcyc, exp_ct >= 0);
        end
        nz = 0;
        for (int i = 0; i <= exp_ct; i++) if (mem[i] != 16'h0) nz++;
        total++;
        if (nz != 0) begin bad++; $display("FAIL %s mem_zero: got %0d nonzero words, expected 0", nm, nz); end
    endtask

    task automatic test_reset_mid_clear();
        bit   found, ok;
        int   done_len, d;
        req_t first_exp;
        mode = 0;
        build_exp(0, VERIFY_ON);
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 10000 && !found; i++) begin
            @(negedge clk_sys);
            if (sd_we && clr_busy && sd_addr == 8'h37) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL midclr_reach: got no clear write at 37, expected one"); end
        RESET = 1'b1;
        @(posedge clk_sys);
        #1;
        total++;
        if ({sd_we, sd_rd, sd_addr, sd_din, size_cfg, cfg_valid, clr_busy, clr_done, err}
            !== '0) begin
            bad++;
            $display("FAIL midclr_reset_outputs: got we=%b addr=%h cfg=%b v=%b busy=%b done=%b, expected all 0",
                     sd_we, sd_addr, size_cfg, cfg_valid, clr_busy, clr_done);
        end
        apply_reset();
        run_to_done(20000, ok, done_len);
        first_exp = {1'b0, 8'h80, 16'd3128};
        total++;
        if (log_q.size() <= base_log || !same_req(log_q[base_log], first_exp)) begin
            bad++;
            $display("FAIL midclr_restart: got %0d requests after reset, expected first write 3128 at 80",
                     log_q.size() - base_log);
        end
        d = first_diff(base_log);
        total++;
        if (!ok || d >= 0 || size_cfg !== 3'b111) begin
            bad++; $display("FAIL midclr_rerun: got done=%b diff=%0d cfg=%b, expected done=1 diff=-1 cfg=111",
                            ok, d, size_cfg);
        end
    endtask

    task automatic test_slow_ready();
        bit ok;
        int done_len, d;
        slow = 1'b1;
        mode = 1;
        build_exp(1, VERIFY_ON);
        apply_reset();
        run_to_done(40000, ok, done_len);
        d = first_diff(base_log);
        total++;
        if (!ok || d >= 0) begin
            bad++; $display("FAIL slow_log: got done=%b diff=%0d, expected done=1 diff=-1", ok, d);
        end
        total++;
        if (viol != base_viol) begin
            bad++; $display("FAIL slow_protocol: got %0d violations, expected 0", viol - base_viol);
        end
        slow = 1'b0;
    endtask

`ifdef SDRAM_PROBE_VERIFY_EN
    task automatic test_verify_err();
        bit ok;
        int done_len, d;
        mode  = 0;
        bad10 = 1'b1;
        build_exp(0, 1'b1);
        apply_reset();
        run_to_done(20000, ok, done_len);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL verify_err: got %b, expected 1", err); end
        d = first_diff(base_log);
        total++;
        if (!ok || d >= 0) begin
            bad++; $display("FAIL verify_log: got done=%b diff=%0d, expected done=1 diff=-1", ok, d);
        end
        total++;
        if (done_len - base_log != exp_q.size()) begin
            bad++; $display("FAIL verify_done_order: got %0d requests at done, expected %0d",
                            done_len - base_log, exp_q.size());
        end
        bad10 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_size_detect(0, "full");
        test_size_detect(1, "small");
        test_size_detect(2, "none");
        test_reset_mid_clear();
        test_slow_ready();
`ifdef SDRAM_PROBE_VERIFY_EN
        test_verify_err();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
